uart_stream_core: RTL
=====================

# uart_stream_core

Parametrised UART transceiver: next generation of the board's RS232 datapath. It merges receive, transmit and baud timing into one block and adds:
- configurable frame format (data bits, parity);
- a receive FIFO with valid/ready handshakes;
- error reporting;
- a build-time echo mode that loops received bytes back out.

It sits between the RS232 pins and user logic such as the digit display, and the `last_rx` port feeds the display directly.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `BAUD`, 9600: line rate. `DIV = CLK_HZ/BAUD` (integer division), DIV ≥ 4.
- `DATA_BITS`, 8: data bits per frame, 5..8.
- `PARITY`, 0: parity mode. 0 = none, 1 = even, 2 = odd.
- `FIFO_DEPTH`, 4: receive FIFO entries, power of two, ≥ 2.
- `ECHO`, 0: 1 = received bytes are retransmitted automatically.

Ports:
- `clk` in 1: system clock. One clock domain; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rs232_rx` in 1: serial input, asynchronous to `clk`.
- `rs232_tx` out 1: serial output, idle high.
- `tx_data` in DATA_BITS: byte to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: transmitter accepts a byte.
- `rx_data` out DATA_BITS: FIFO head.
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: consumer pops the head.
- `last_rx` out DATA_BITS: most recent good byte, held for display.
- `frame_err` out 1: one-cycle pulse, stop bit sampled low.
- `parity_err` out 1: one-cycle pulse, parity mismatch.
- `overrun` out 1: one-cycle pulse, good byte dropped because the FIFO was full.

## Operation
**RX path**
- `rs232_rx` passes through a 2-flop synchroniser.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE → START on a synchronised falling edge. Then wait DIV/2 cycles and sample the line.
  - Line high: glitch. Return to IDLE, no flag.
  - Line low: go to DATA.
- DATA samples every DIV cycles, LSB first, DATA_BITS samples.
- PARITY state is skipped when PARITY = 0.
- STOP samples once.
  - Stop bit low: pulse `frame_err`, discard the byte.
  - Else parity mismatch: pulse `parity_err`, discard the byte.
  - Else good byte: update `last_rx`, then push to the FIFO, or pulse `overrun` and drop the byte if the FIFO is full.
- FSM returns to IDLE in the same cycle as the STOP sample. It may detect a new start edge on the next cycle.

**FIFO**
- `rx_valid = !empty`. A pop occurs when `rx_valid && rx_ready`.
- Simultaneous push and pop while full: both succeed, no `overrun`.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.

**TX path**
- States: IDLE, START, DATA, PARITY, STOP.
- Each bit is held for exactly DIV cycles. Frame length is `(2 + DATA_BITS + (PARITY != 0)) * DIV` cycles.
- ECHO = 0: a byte is accepted on `tx_valid && tx_ready`. `tx_ready = (tx state == IDLE)`.
- ECHO = 1:
  - The TX source is the FIFO head. TX pops the head when idle and the FIFO is non-empty.
  - `rx_valid` is forced to 0, `tx_ready` to 0, and `tx_valid` is ignored.
  - `last_rx` still updates.

**Parity and width rules**
- Even parity makes the total count of ones, data plus parity bit, even.
- Odd parity makes that count odd.
- Upper bits of `tx_data` beyond DATA_BITS do not exist; the width is exactly DATA_BITS.

## Timing
**Reset values**
- `rs232_tx` = 1.
- `rx_valid`, `frame_err`, `parity_err`, `overrun` = 0.
- `last_rx` = 0, `rx_data` = 0 (FIFO storage is cleared).
- `tx_ready` = 1 when ECHO = 0, else 0.
- Both FSMs are in IDLE and the FIFO is empty.

**Reset mid-frame**
- `rs232_tx` goes high asynchronously.
- A partial RX byte is discarded and no flags are raised.

**RX latency**
- The push happens on the STOP-sample edge; `rx_valid` is high from the next cycle.
- The STOP sample lands (1.5 + DATA_BITS + P) × DIV cycles after the synchronised start edge, where P = (PARITY != 0). There are 2 further cycles of synchroniser delay.

**TX latency**
- `rs232_tx` falls on the cycle after the accept edge.
- `tx_ready` returns high on the cycle after the last stop-bit cycle.
- Back-to-back frames have no idle gap beyond that 1 cycle.

**Echo latency**
- The FIFO pop and TX start happen on the cycle after `rx_valid` would assert.

## Structure
Shared package `uart_pkg` holds:
- the parity-mode constants;
- the RX and TX state encodings;
- a constant function computing DIV and counter widths from CLK_HZ and BAUD.

Sub-module `uart_sync_fifo` provides the parametrised DATA_BITS × FIFO_DEPTH storage, push/pop, empty/full. Baud counters stay inline, one per direction.

## Test plan
Bench parameters: CLK_HZ = 50_000_000, BAUD = 5_000_000 (DIV = 10), DATA_BITS = 8, FIFO_DEPTH = 4, unless a scenario states otherwise.

1. 8N1 frame 0xA5 on `rs232_rx`, `rx_ready` = 0 → `rx_valid` = 1 with `rx_data` = 0xA5 and `last_rx` = 0xA5; no error pulse.
2. PARITY = 1, byte 0x07 sent with parity bit 0 → one `parity_err` pulse, FIFO stays empty, `last_rx` unchanged.
3. Stop bit driven low after 0x3C → one `frame_err` pulse, no push.
4. Five bytes 0x01..0x05 with `rx_ready` = 0 → exactly one `overrun` on the fifth byte; pops return 0x01..0x04 in order.
5. `tx_data` = 0x5A accepted → `rs232_tx` shows start, bits 0,1,0,1,1,0,1,0, stop, each 10 cycles; `tx_ready` is low for 100 cycles.
6. ECHO = 1: 0xC3 received → 0xC3 frame appears on `rs232_tx`. Also a 3-cycle low glitch on `rs232_rx` → no FIFO activity, no flags.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, state encodings and timing helpers for the UART stream core.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    function automatic int calc_div(int clk_hz, int baud);
        return clk_hz / baud;
    endfunction

    function automatic int calc_cw(int div);
        int w;
        w = 1;
        while ((1 << w) < div) w++;
        return w;
    endfunction

    // Narrow data is zero-extended; the extra zeros do not change the XOR.
    function automatic logic calc_parity(int mode, logic [7:0] d);
        return (mode == PAR_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Receive FIFO: DATA_BITS x FIFO_DEPTH storage with wrap-bit pointers.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW])
                  && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same edge, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_stream_core.sv
// UART transceiver: synchronised RX with error flags, RX FIFO, TX and echo.
module uart_stream_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int ECHO       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rs232_rx,
    output logic                 rs232_tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] last_rx,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int              DIV     = calc_div(CLK_HZ, BAUD);
    localparam int              CW      = calc_cw(DIV);
    localparam logic [CW-1:0]   LAST    = CW'(DIV - 1);
    localparam logic [CW-1:0]   HALF    = CW'(DIV / 2 - 1);
    localparam logic [2:0]      TOP     = 3'(DATA_BITS - 1);
    localparam bit              HAS_PAR = (PARITY != PAR_NONE);
    localparam bit              ECHO_ON = (ECHO != 0);

    logic                 rx_s1, rx_s2, rx_prev, rx_fall, rx_line;
    rx_state_t            rx_st, rx_nxt;
    logic [CW-1:0]        rx_cnt, rx_cnt_nxt;
    logic [2:0]           rx_idx, rx_idx_nxt;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_nxt;
    logic                 rx_par, rx_par_nxt;
    logic                 stop_hit, par_ok, good;

    logic                 push, pop, empty, full;
    logic [DATA_BITS-1:0] fifo_dout;

    tx_state_t            tx_st, tx_nxt;
    logic [CW-1:0]        tx_cnt, tx_cnt_nxt;
    logic [2:0]           tx_idx, tx_idx_nxt;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_nxt, tx_src;
    logic                 tx_par, tx_par_nxt;
    logic                 tx_go, tx_accept, line_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rs232_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_line = rx_s2;
    assign rx_fall = rx_prev && !rx_s2;

    always_comb begin
        rx_nxt     = rx_st;
        rx_cnt_nxt = rx_cnt + 1'b1;
        rx_idx_nxt = rx_idx;
        rx_sh_nxt  = rx_sh;
        rx_par_nxt = rx_par;
        stop_hit   = 1'b0;
        unique case (rx_st)
            RX_IDLE: begin
                rx_cnt_nxt = '0;
                rx_idx_nxt = '0;
                if (rx_fall) rx_nxt = RX_START;
            end
            RX_START: if (rx_cnt == HALF) begin
                rx_cnt_nxt = '0;
                rx_nxt     = rx_line ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == LAST) begin
                rx_cnt_nxt = '0;
                rx_sh_nxt  = {rx_line, rx_sh[DATA_BITS-1:1]};
                rx_idx_nxt = rx_idx + 1'b1;
                if (rx_idx == TOP) rx_nxt = HAS_PAR ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (rx_cnt == LAST) begin
                rx_cnt_nxt = '0;
                rx_par_nxt = rx_line;
                rx_nxt     = RX_STOP;
            end
            RX_STOP: if (rx_cnt == LAST) begin
                rx_cnt_nxt = '0;
                stop_hit   = 1'b1;
                rx_nxt     = RX_IDLE;
            end
            default: rx_nxt = RX_IDLE;
        endcase
    end

    assign par_ok = !HAS_PAR || (rx_par == calc_parity(PARITY, 8'(rx_sh)));
    assign good   = stop_hit && rx_line && par_ok;
    assign push   = good;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_st      <= RX_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_sh      <= '0;
            rx_par     <= 1'b0;
            last_rx    <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_st      <= rx_nxt;
            rx_cnt     <= rx_cnt_nxt;
            rx_idx     <= rx_idx_nxt;
            rx_sh      <= rx_sh_nxt;
            rx_par     <= rx_par_nxt;
            frame_err  <= stop_hit && !rx_line;
            parity_err <= stop_hit && rx_line && !par_ok;
            overrun    <= good && full && !pop;
            if (good) last_rx <= rx_sh;
        end
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (rx_sh),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (empty),
        .full  (full)
    );

    // In echo mode the transmitter is the only FIFO consumer.
    assign rx_valid = !ECHO_ON && !empty;
    assign rx_data  = fifo_dout;
    assign pop      = ECHO_ON ? tx_accept : (!empty && rx_ready);
    assign tx_ready = !ECHO_ON && (tx_st == TX_IDLE);
    assign tx_go    = ECHO_ON ? !empty : tx_valid;
    assign tx_src   = ECHO_ON ? fifo_dout : tx_data;

    always_comb begin
        tx_nxt     = tx_st;
        tx_cnt_nxt = tx_cnt + 1'b1;
        tx_idx_nxt = tx_idx;
        tx_sh_nxt  = tx_sh;
        tx_par_nxt = tx_par;
        line_nxt   = rs232_tx;
        tx_accept  = 1'b0;
        unique case (tx_st)
            TX_IDLE: begin
                tx_cnt_nxt = '0;
                tx_idx_nxt = '0;
                line_nxt   = 1'b1;
                if (tx_go) begin
                    tx_accept  = 1'b1;
                    tx_sh_nxt  = tx_src;
                    tx_par_nxt = calc_parity(PARITY, 8'(tx_src));
                    tx_nxt     = TX_START;
                    line_nxt   = 1'b0;
                end
            end
            TX_START: if (tx_cnt == LAST) begin
                tx_cnt_nxt = '0;
                tx_nxt     = TX_DATA;
                line_nxt   = tx_sh[0];
            end
            TX_DATA: if (tx_cnt == LAST) begin
                tx_cnt_nxt = '0;
                if (tx_idx == TOP) begin
                    tx_nxt   = HAS_PAR ? TX_PARITY : TX_STOP;
                    line_nxt = HAS_PAR ? tx_par : 1'b1;
                end else begin
                    tx_idx_nxt = tx_idx + 1'b1;
                    tx_sh_nxt  = tx_sh >> 1;
                    line_nxt   = tx_sh[1];
                end
            end
            TX_PARITY: if (tx_cnt == LAST) begin
                tx_cnt_nxt = '0;
                tx_nxt     = TX_STOP;
                line_nxt   = 1'b1;
            end
            TX_STOP: if (tx_cnt == LAST) begin
                tx_cnt_nxt = '0;
                tx_nxt     = TX_IDLE;
                line_nxt   = 1'b1;
            end
            default: begin
                tx_nxt   = TX_IDLE;
                line_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_st    <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            rs232_tx <= 1'b1;
        end else begin
            tx_st    <= tx_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_idx   <= tx_idx_nxt;
            tx_sh    <= tx_sh_nxt;
            tx_par   <= tx_par_nxt;
            rs232_tx <= line_nxt;
        end
    end

endmodule
